// File: rtl/alu_datapath.sv
// alu_datapath: 8-bit ALU datapath driven by the ALU_CU control word.
// Holds A/Q/Q_1/M, an iteration counter, an output register and done/overflow
// flags. The status flags the control unit branches on come straight off the
// registers, so they reflect the previous control pulse with no extra delay.
module alu_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] INBUS,
    input  logic             c0,
    input  logic             c0_prim,
    input  logic             c1,
    input  logic             c2,
    input  logic             c3,
    input  logic             cR,
    input  logic             cL,
    input  logic             c4,
    input  logic             c5,
    input  logic             c6,
    input  logic             c7,
    input  logic             c8,
    input  logic             c7_5,
    output logic [WIDTH-1:0] OUTBUS,
    output logic             CNT7,
    output logic             Q0,
    output logic             Q_1,
    output logic             A7,
    output logic             OVF,
    output logic             DONE
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_q1;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_done;

    logic             w_shr;
    logic             w_shl;
    logic [WIDTH-1:0] w_q_ld;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_q1_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    // cR together with cL is illegal; it collapses to no shift and no count.
    assign w_shr  = cR & ~cL;
    assign w_shl  = cL & ~cR;

    // Q is loaded first, so a shift in the same cycle acts on the loaded value.
    assign w_q_ld = c0_prim ? INBUS : r_q;

    assign w_sum  = r_a + r_m;
    assign w_diff = r_a + ~r_m + {{(WIDTH-1){1'b0}}, 1'b1};

    // Signed overflow: result sign flips away from A where the operation cannot
    // legitimately change it.
    assign w_add_ovf = (r_a[WIDTH-1] == r_m[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1]);
    assign w_sub_ovf = (r_a[WIDTH-1] != r_m[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);

    // Next-state for A (priority c0 > c1 > c2 > c3 > shift) and for overflow.
    always_comb begin
        w_a_nxt   = r_a;
        w_ovf_nxt = r_ovf;
        if (c0) begin
            w_a_nxt   = '0;
            w_ovf_nxt = 1'b0;
        end else if (c1) begin
            w_a_nxt = r_q;
        end else if (c2) begin
            w_a_nxt   = w_sum;
            w_ovf_nxt = r_ovf | w_add_ovf;
        end else if (c3) begin
            w_a_nxt   = w_diff;
            w_ovf_nxt = r_ovf | w_sub_ovf;
        end else if (w_shr) begin
            w_a_nxt = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        end else if (w_shl) begin
            w_a_nxt = {r_a[WIDTH-2:0], w_q_ld[WIDTH-1]};
        end
    end

    // Next-state for Q (load, then shift, then bit write), Q_1 and the counter.
    always_comb begin
        w_q_nxt   = w_q_ld;
        w_q1_nxt  = r_q1;
        w_cnt_nxt = r_cnt;
        if (w_shr) begin
            w_q_nxt = {r_a[0], w_q_ld[WIDTH-1:1]};
        end else if (w_shl) begin
            w_q_nxt = {w_q_ld[WIDTH-2:0], 1'b0};
        end
        if (c4) begin
            w_q_nxt[0] = 1'b1;
        end else if (c5) begin
            w_q_nxt[0] = 1'b0;
        end
        if (c0) begin
            w_q1_nxt  = 1'b0;
            w_cnt_nxt = '0;
        end else if (w_shr || w_shl) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_shr) begin
                w_q1_nxt = w_q_ld[0];
            end
        end
    end

    // Register update; reset overrides every control input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a    <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_q1   <= 1'b0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= w_q1_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            if (c0) begin
                r_m <= INBUS;
            end
            if (c8) begin
                r_out <= r_q;
            end else if (c7) begin
                r_out <= r_a;
            end
            if (c7_5) begin
                r_done <= 1'b1;
            end else if (c6) begin
                r_done <= 1'b0;
            end
        end
    end

    assign OUTBUS = r_out;
    assign CNT7   = &r_cnt;
    assign Q0     = r_q[0];
    assign Q_1    = r_q1;
    assign A7     = r_a[WIDTH-1];
    assign OVF    = r_ovf;
    assign DONE   = r_done;

endmodule

// File: tb/tb_alu_datapath.sv
// Bench for alu_datapath: directed scenarios plus random control words,
// checked every cycle against a queue of expected outputs from an
// arithmetic reference model.
module tb_alu_datapath;

    localparam logic [12:0] C0  = 13'd1;
    localparam logic [12:0] C0P = 13'd2;
    localparam logic [12:0] C1  = 13'd4;
    localparam logic [12:0] C2  = 13'd8;
    localparam logic [12:0] C3  = 13'd16;
    localparam logic [12:0] CR  = 13'd32;
    localparam logic [12:0] CL  = 13'd64;
    localparam logic [12:0] C4  = 13'd128;
    localparam logic [12:0] C5  = 13'd256;
    localparam logic [12:0] C6  = 13'd512;
    localparam logic [12:0] C7  = 13'd1024;
    localparam logic [12:0] C8  = 13'd2048;
    localparam logic [12:0] C75 = 13'd4096;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  INBUS;
    logic [12:0] ctl;
    logic [7:0]  OUTBUS;
    logic        CNT7, Q0, Q_1, A7, OVF, DONE;

    always #5 CLK = ~CLK;

    alu_datapath #(.WIDTH(8), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .INBUS(INBUS),
        .c0(ctl[0]), .c0_prim(ctl[1]), .c1(ctl[2]), .c2(ctl[3]), .c3(ctl[4]),
        .cR(ctl[5]), .cL(ctl[6]), .c4(ctl[7]), .c5(ctl[8]), .c6(ctl[9]),
        .c7(ctl[10]), .c8(ctl[11]), .c7_5(ctl[12]),
        .OUTBUS(OUTBUS), .CNT7(CNT7), .Q0(Q0), .Q_1(Q_1), .A7(A7),
        .OVF(OVF), .DONE(DONE)
    );

    typedef struct {
        logic [7:0] out;
        logic       cnt7;
        logic       q0;
        logic       q1;
        logic       a7;
        logic       ovf;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0] m_a, m_q, m_m, m_out;
    logic       m_q1, m_ovf, m_done;
    int         m_cnt;

    function automatic int sgn8(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model of one clock edge, written from the operation definitions:
    // {A,Q,Q_1} as a 17-bit signed value for cR, {A,Q} as 16 bits for cL,
    // signed integer range checks for overflow.
    task automatic model(input logic rst, input logic [12:0] cw, input logic [7:0] din);
        logic [7:0]         na, nq, qv;
        logic               nq1;
        logic signed [16:0] v;
        logic [15:0]        w;
        int                 r;
        bit                 shr, shl;
        if (rst) begin
            m_a = 0; m_q = 0; m_m = 0; m_out = 0;
            m_q1 = 0; m_ovf = 0; m_done = 0; m_cnt = 0;
            return;
        end
        shr = cw[5] && !cw[6];
        shl = cw[6] && !cw[5];
        qv  = cw[1] ? din : m_q;
        v   = {m_a, qv, m_q1};
        v   = v >>> 1;
        w   = {m_a, qv} << 1;
        if (cw[11])      m_out = m_q;
        else if (cw[10]) m_out = m_a;
        na = m_a;
        if (cw[0]) begin
            na = 0;
            m_ovf = 0;
        end else if (cw[2]) begin
            na = m_q;
        end else if (cw[3]) begin
            r  = sgn8(m_a) + sgn8(m_m);
            na = r[7:0];
            if (r > 127 || r < -128) m_ovf = 1;
        end else if (cw[4]) begin
            r  = sgn8(m_a) - sgn8(m_m);
            na = r[7:0];
            if (r > 127 || r < -128) m_ovf = 1;
        end else if (shr) begin
            na = v[16:9];
        end else if (shl) begin
            na = w[15:8];
        end
        nq = qv;
        if (shr)      nq = v[8:1];
        else if (shl) nq = w[7:0];
        if (cw[7])      nq[0] = 1'b1;
        else if (cw[8]) nq[0] = 1'b0;
        nq1 = m_q1;
        if (cw[0])    nq1 = 0;
        else if (shr) nq1 = v[0];
        if (cw[0])             m_cnt = 0;
        else if (shr || shl)   m_cnt = (m_cnt + 1) % 8;
        if (cw[0]) m_m = din;
        if (cw[12])     m_done = 1;
        else if (cw[9]) m_done = 0;
        m_a  = na;
        m_q  = nq;
        m_q1 = nq1;
    endtask

    // Drive one cycle; the expected outputs after the edge go to the scoreboard.
    task automatic step(input logic rst, input logic [12:0] cw, input logic [7:0] din);
        exp_t e;
        RST   = rst;
        ctl   = cw;
        INBUS = din;
        model(rst, cw, din);
        e.out  = m_out;
        e.cnt7 = (m_cnt == 7);
        e.q0   = m_q[0];
        e.q1   = m_q1;
        e.a7   = m_a[7];
        e.ovf  = m_ovf;
        e.done = m_done;
        exp_q.push_back(e);
        n_vec++;
        @(posedge CLK);
        #3;
    endtask

    // Monitor: every cycle the DUT presents the result of the edge just taken.
    always @(posedge CLK) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_outbus", OUTBUS, mon_e.out);
            chk("sb_cnt7",   CNT7,   mon_e.cnt7);
            chk("sb_q0",     Q0,     mon_e.q0);
            chk("sb_q_1",    Q_1,    mon_e.q1);
            chk("sb_a7",     A7,     mon_e.a7);
            chk("sb_ovf",    OVF,    mon_e.ovf);
            chk("sb_done",   DONE,   mon_e.done);
        end
    end

    // Illegal control combination flag.
    always @(posedge CLK) begin
        if (!RST && ctl[5] && ctl[6])
            $display("note: illegal cR+cL in the same cycle at %0t", $time);
    end

    initial begin
        logic [12:0] cw;
        int          k;
        RST = 1'b1; ctl = '0; INBUS = '0;
        #2;
        step(1, 0, 0);
        chk("rst_outbus", OUTBUS, 8'h00);
        chk("rst_done", DONE, 1'b0);

        // add
        step(0, C0, 8'h25);
        step(0, C0P, 8'h13);
        step(0, C1, 0);
        step(0, C2, 0);
        step(0, C7, 0);
        chk("add_out", OUTBUS, 8'h38);
        chk("add_ovf", OVF, 1'b0);
        chk("add_a7", A7, 1'b0);

        // subtract with overflow
        step(0, C0, 8'h01);
        step(0, C0P, 8'h80);
        step(0, C1, 0);
        step(0, C3, 0);
        chk("sub_ovf", OVF, 1'b1);
        chk("sub_a7", A7, 1'b0);
        step(0, C7, 0);
        chk("sub_out", OUTBUS, 8'h7F);
        chk("sub_ovf_sticky", OVF, 1'b1);
        step(0, C0, 8'h01);
        chk("sub_ovf_clr", OVF, 1'b0);

        // Booth multiply -5 * 3, bench plays the control unit
        step(0, C0, 8'hFB);
        step(0, C0P, 8'h03);
        for (int i = 0; i < 8; i++) begin
            if (Q0 && !Q_1)      step(0, C3, 0);
            else if (!Q0 && Q_1) step(0, C2, 0);
            if (i == 7) chk("booth_cnt7", CNT7, 1'b1);
            step(0, CR, 0);
        end
        chk("booth_cnt7_wrap", CNT7, 1'b0);
        step(0, C7, 0);
        chk("booth_hi", OUTBUS, 8'hFF);
        step(0, C8, 0);
        chk("booth_lo", OUTBUS, 8'hF1);

        // counter wrap and conflicting controls
        step(0, C0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(0, CR, 0);
            chk("cnt_wrap", CNT7, (i == 6) ? 1'b1 : 1'b0);
        end
        step(0, C0P, 8'h40);
        step(0, CR | CL, 0);
        chk("crcl_q0", Q0, 1'b0);
        chk("crcl_cnt7", CNT7, 1'b0);
        step(0, CL | C4, 0);
        step(0, C8, 0);
        chk("cl_c4", OUTBUS, 8'h81);
        step(0, C4 | C5 | C7 | C8 | C6 | C75, 0);
        chk("c4c5_q0", Q0, 1'b1);
        chk("c7c8_out", OUTBUS, 8'h81);
        chk("c6c75_done", DONE, 1'b1);

        // reset mid-operation
        step(0, C0, 8'h55);
        step(0, C0P, 8'hAA);
        for (int i = 0; i < 3; i++) step(0, CR, 0);
        step(0, C75 | C7, 0);
        chk("pre_rst_done", DONE, 1'b1);
        step(1, C0 | C0P | C7 | C75 | CR | C4, 8'h33);
        chk("rst_out0", OUTBUS, 8'h00);
        chk("rst_cnt7", CNT7, 1'b0);
        chk("rst_q0", Q0, 1'b0);
        chk("rst_q1", Q_1, 1'b0);
        chk("rst_a7", A7, 1'b0);
        chk("rst_ovf", OVF, 1'b0);
        chk("rst_done2", DONE, 1'b0);
        step(0, 0, 0);
        chk("idle_out", OUTBUS, 8'h00);
        chk("idle_done", DONE, 1'b0);

        // random control words
        for (int n = 0; n < 400; n++) begin
            cw = '0;
            for (int b = 0; b < 13; b++)
                if ($urandom_range(0, 5) == 0) cw[b] = 1'b1;
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, cw, 8'($urandom));
        end
        step(0, 0, 0);

        k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            @(posedge CLK);
            k++;
        end
        #4;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
